// File: rtl/instr_fetch.sv
// Instruction fetch stage: samples nextPC, runs a req/ack transaction to
// instruction memory and holds the fetched word for decode until released.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] nextPC,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] PC_plus_four,
    output logic        instr_valid,
    output logic        misaligned,
    output logic        timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic [1:0] state;
    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            imem_req     <= 1'b0;
            imem_addr    <= 32'h0;
            instr        <= 32'h0;
            instr_valid  <= 1'b0;
            instr_pc     <= RESET_PC;
            PC_plus_four <= RESET_PC + 32'd4;
            misaligned   <= 1'b0;
            timeout      <= 1'b0;
            wait_cnt     <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (nextPC[1:0] != 2'b00) begin
                        misaligned <= 1'b1;
                        state      <= S_ERR;
                    end else begin
                        imem_addr <= nextPC;
                        imem_req  <= 1'b1;
                        wait_cnt  <= 8'd0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A late ack in the final window cycle still wins over timeout.
                    if (imem_ack) begin
                        instr        <= imem_rdata;
                        instr_pc     <= imem_addr;
                        PC_plus_four <= imem_addr + 32'd4;
                        instr_valid  <= 1'b1;
                        imem_req     <= 1'b0;
                        state        <= S_HOLD;
                    end else if (wait_cnt == MAX_W) begin
                        timeout  <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_ERR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one task per scenario, inline checks.
module tb_instr_fetch;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] nextPC;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] PC_plus_four;
    logic        instr_valid;
    logic        misaligned;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(.RESET_PC(RPC), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .nextPC(nextPC), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .PC_plus_four(PC_plus_four), .instr_valid(instr_valid),
        .misaligned(misaligned), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in IDLE with rst low; the next edge samples nextPC.
    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; nextPC = 32'h0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        tick(); tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr_pc !== 32'h100) begin n_fail++; $display("FAIL reset_pc: got %h want 00000100", instr_pc); end
        n_checks++; if (PC_plus_four !== 32'h104) begin n_fail++; $display("FAIL reset_pc4: got %h want 00000104", PC_plus_four); end
        n_checks++; if ({misaligned, timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {misaligned, timeout}); end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        nextPC = 32'h0;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        tick();
        imem_ack = 1'b0;
        n_checks++; if (instr !== 32'h2008_0005) begin n_fail++; $display("FAIL basic_instr: got %h want 20080005", instr); end
        n_checks++; if (instr_pc !== 32'h0 || PC_plus_four !== 32'h4) begin n_fail++; $display("FAIL basic_pc: got %h/%h want 0/4", instr_pc, PC_plus_four); end
        n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_valid: got v=%b req=%b want 1/0", instr_valid, imem_req); end
        nextPC = 32'h4;
        tick();
        n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_release: got v=%b req=%b want 0/0", instr_valid, imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_next_req: got req=%b addr=%h want 1/4", imem_req, imem_addr); end
    endtask

    task automatic test_wait_stall();
        do_reset();
        nextPC = 32'h40;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL wait_req[%0d]: got req=%b addr=%h want 1/40", i, imem_req, imem_addr); end
            imem_ack = (i == 3); imem_rdata = 32'h8C09_0004;
            tick();
        end
        n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL wait_capture: got v=%b req=%b want 1/0", instr_valid, imem_req); end
        n_checks++; if (instr_pc !== 32'h40 || PC_plus_four !== 32'h44) begin n_fail++; $display("FAIL wait_pc: got %h/%h want 40/44", instr_pc, PC_plus_four); end
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h8C09_0004) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b instr=%h want 1/8c090004", i, instr_valid, instr); end
        end
        stall = 1'b0; imem_ack = 1'b0;
        tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", instr_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        nextPC = 32'h10;
        tick();
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (imem_req !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_req[%0d]: got req=%b to=%b want 1/0", i, imem_req, timeout); end
            tick();
        end
        n_checks++; if (timeout !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL to_err: got to=%b req=%b v=%b want 1/0/0", timeout, imem_req, instr_valid); end
        imem_ack = 1'b1; nextPC = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (timeout !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL to_sticky[%0d]: got to=%b req=%b v=%b want 1/0/0", i, timeout, imem_req, instr_valid); end
        end
        imem_ack = 1'b0;
        // Ack in the last allowed REQ cycle must still capture.
        do_reset();
        nextPC = 32'h8;
        tick();
        for (int i = 0; i < 16; i++) begin
            imem_ack = (i == 15); imem_rdata = 32'h0123_4567;
            tick();
        end
        imem_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL late_ack: got v=%b to=%b want 1/0", instr_valid, timeout); end
        n_checks++; if (instr !== 32'h0123_4567 || instr_pc !== 32'h8) begin n_fail++; $display("FAIL late_ack_data: got %h@%h want 01234567@8", instr, instr_pc); end
    endtask

    task automatic test_misaligned();
        do_reset();
        nextPC = 32'h0000_0102;
        tick();
        n_checks++; if (misaligned !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got mis=%b req=%b want 1/0", misaligned, imem_req); end
        nextPC = 32'h0; imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (misaligned !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL mis_sticky[%0d]: got mis=%b req=%b v=%b want 1/0/0", i, misaligned, imem_req, instr_valid); end
        end
        imem_ack = 1'b0; rst = 1'b1;
        tick();
        n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", misaligned); end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        nextPC = 32'h80;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0; nextPC = 32'h84;
        tick(); tick();
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h84) begin n_fail++; $display("FAIL mid_setup: got req=%b addr=%h want 1/84", imem_req, imem_addr); end
        rst = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_req: got req=%b addr=%h want 0/0", imem_req, imem_addr); end
        n_checks++; if (instr !== 32'h0 || instr_pc !== RPC || PC_plus_four !== 32'h104) begin n_fail++; $display("FAIL mid_regs: got %h/%h/%h want 0/100/104", instr, instr_pc, PC_plus_four); end
        n_checks++; if ({instr_valid, misaligned, timeout} !== 3'b000) begin n_fail++; $display("FAIL mid_flags: got %b want 000", {instr_valid, misaligned, timeout}); end
    endtask

    task automatic test_wrap();
        do_reset();
        nextPC = 32'hFFFF_FFFC;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h0000_000C;
        tick();
        imem_ack = 1'b0;
        n_checks++; if (instr_pc !== 32'hFFFF_FFFC || PC_plus_four !== 32'h0) begin n_fail++; $display("FAIL wrap: got %h/%h want fffffffc/0", instr_pc, PC_plus_four); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_wait_stall();
        test_timeout();
        test_misaligned();
        test_reset_mid_req();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the MINI-MIPS core, directly downstream of the PC update stage. It samples `nextPC` and issues a request/acknowledge transaction to instruction memory. It then holds the fetched word, its address and `PC_plus_four` for decode until decode releases it. `PC_plus_four` feeds back to the PC update stage, which closes the PC loop. Memory latency is variable, and the stage flags misaligned targets and memory timeouts.

## Interface
Parameters:
- `RESET_PC`, 32'd0: value of `instr_pc` after reset; `PC_plus_four` resets to `RESET_PC+4`.
- `MAX_WAIT`, 15: last REQ cycle index in which `imem_ack` is still accepted; range 1..255.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `nextPC`  in  32  fetch target from the PC update stage.
- `stall`  in  1  decode not ready; while high, the held instruction stays.
- `imem_req`  out  1  memory request.
- `imem_addr`  out  32  request address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory data valid this cycle; ignored unless `imem_req`=1.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack`=1.
- `instr`  out  32  fetched instruction.
- `instr_pc`  out  32  address of `instr`.
- `PC_plus_four`  out  32  `instr_pc + 4`, mod 2^32.
- `instr_valid`  out  1  `instr` is valid for decode.
- `misaligned`  out  1  sticky: sampled `nextPC[1:0]` was not 0.
- `timeout`  out  1  sticky: no `imem_ack` within the `MAX_WAIT` window.

## Operation
States: IDLE, REQ, HOLD, ERR. Outputs are registered; no combinational path runs from input to output.

Reset (`rst`=1 at an edge):
- state becomes IDLE.
- `imem_req`=0, `imem_addr`=0, `instr`=32'h0 (NOP), `instr_valid`=0.
- `instr_pc`=`RESET_PC`, `PC_plus_four`=`RESET_PC+4`.
- `misaligned`=0, `timeout`=0, wait counter=0.
- Reset overrides every state, including mid-REQ. `imem_req` drops at that edge, and memory must tolerate the abandoned request.

IDLE:
- Samples `nextPC`.
- If `nextPC[1:0]`≠0: go to ERR, `misaligned`<=1, no request issued.
- Otherwise: `imem_addr`<=`nextPC`, `imem_req`<=1, counter<=0, go to REQ.

REQ:
- `imem_req` and `imem_addr` are held constant.
- On `imem_ack`=1:
  - `instr`<=`imem_rdata`, `instr_pc`<=`imem_addr`, `PC_plus_four`<=`imem_addr+4`.
  - `instr_valid`<=1, `imem_req`<=0, go to HOLD.
- Else if counter==`MAX_WAIT`: `timeout`<=1, `imem_req`<=0, go to ERR.
- Else: counter<=counter+1.
- Ack in the cycle where counter==`MAX_WAIT` counts as success; ack wins over timeout.

HOLD:
- `instr`, `instr_pc`, `PC_plus_four` and `instr_valid` are held.
- `stall`=1: stay in HOLD.
- `stall`=0: `instr_valid`<=0, go to IDLE. Decode consumes the word in this cycle.
- The IDLE cycle gives the PC update stage one edge to register `nextPC` from the new `PC_plus_four`/branch inputs.

ERR:
- `imem_req`=0, `instr_valid`=0, sticky flags held.
- Exits only on `rst`.

`PC_plus_four` wraps: address 32'hFFFFFFFC gives 32'h00000000.

## Timing
- IDLE sample to `imem_req`=1: 1 edge.
- Zero-wait memory (ack in first REQ cycle): `instr_valid`=1 two edges after the IDLE sample.
- Minimum loop with no stall: 3 cycles per instruction (IDLE, REQ, HOLD).
- Each additional memory wait cycle adds exactly 1 cycle.
- Timeout: REQ cycles 0..`MAX_WAIT` with no ack, then ERR on the following edge, `MAX_WAIT+1` cycles after REQ entry.
- Stall in HOLD extends HOLD by exactly the number of stalled cycles.
- `imem_ack` while `imem_req`=0 has no effect.

## Test plan
- Reset release with `nextPC`=0, ack in first REQ cycle, `imem_rdata`=32'h20080005, `stall`=0 -> `imem_addr`=0 in REQ; `instr`=32'h20080005, `instr_pc`=0, `PC_plus_four`=4, `instr_valid` high for exactly 1 cycle; the next request starts 3 cycles after the first.
- `nextPC`=32'h40, ack after 3 wait cycles, `stall` high 2 cycles in HOLD -> `imem_req` high 4 cycles with `imem_addr`=32'h40 stable; `instr_valid` high 3 cycles.
- `MAX_WAIT`=15, ack never -> `imem_req` high 16 cycles, then `timeout`=1, `imem_req`=0, `instr_valid`=0 until reset; ack on the 16th REQ cycle instead -> normal capture, `timeout`=0.
- `nextPC`=32'h00000102 in IDLE -> `misaligned`=1, `imem_req` never asserted, stays in ERR until `rst`.
- `rst` asserted during the second REQ cycle -> next edge: `imem_req`=0, `imem_addr`=0, `instr`=0, `PC_plus_four`=`RESET_PC+4`, all flags 0.
- Fetch at 32'hFFFFFFFC -> `PC_plus_four`=32'h00000000.
